// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the CPU reset sequencer.
package reset_sequencer_pkg;

  // Sequencer states; the encoding is visible on the Phase output.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Generic single-bit two-flop synchroniser with synchronous active-low reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// CPU reset sequencer: waits for a stable PLL lock, holds the core in reset
// through the BRAM init window, then releases it. Lock loss or a software
// request re-enters reset; lock losses out of RUN are counted (saturating).
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES        = 127,
  parameter int LOSS_WIDTH         = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  PllLocked,
  input  logic                  SoftReset,
  output logic                  CpuReset,
  output logic                  Running,
  output logic [1:0]            Phase,
  output logic [LOSS_WIDTH-1:0] LockLossCount
);

  localparam int CNT_RAW = $clog2(max(LOCK_STABLE_CYCLES, HOLD_CYCLES));
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic                  w_lk;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_loss_inc;
  logic [LOSS_WIDTH-1:0] r_loss;
  logic                  r_cpu_reset;
  logic                  r_running;
  logic [1:0]            r_phase;

  sync_2ff u_lock_sync (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_d     (PllLocked),
    .o_q     (w_lk)
  );

  // Next-state logic; priority is lock loss, then SoftReset, then counting.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss_inc  = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lk) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_STABLE: begin
        if (!w_lk) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!w_lk) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (SoftReset) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!w_lk) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_loss_inc  = ~&r_loss;
        end else if (SoftReset) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters and output decodes of the next state, all on one edge.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_loss      <= '0;
      r_cpu_reset <= 1'b1;
      r_running   <= 1'b0;
      r_phase     <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_loss_inc) begin
        r_loss <= r_loss + LOSS_WIDTH'(1);
      end
      r_cpu_reset <= (w_state_nxt != ST_RUN);
      r_running   <= (w_state_nxt == ST_RUN);
      r_phase     <= w_state_nxt;
    end
  end

  assign CpuReset      = r_cpu_reset;
  assign Running       = r_running;
  assign Phase         = r_phase;
  assign LockLossCount = r_loss;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with L=4, H=8, LOSS_WIDTH=2.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int L  = 4;
  localparam int H  = 8;
  localparam int LW = 2;

  logic          Clock;
  logic          Reset;
  logic          PllLocked;
  logic          SoftReset;
  logic          CpuReset;
  logic          Running;
  logic [1:0]    Phase;
  logic [LW-1:0] LockLossCount;

  int n_cmp;
  int n_err;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (L),
    .HOLD_CYCLES        (H),
    .LOSS_WIDTH         (LW)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .PllLocked     (PllLocked),
    .SoftReset     (SoftReset),
    .CpuReset      (CpuReset),
    .Running       (Running),
    .Phase         (Phase),
    .LockLossCount (LockLossCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance n clock edges; returns just after the falling edge that follows
  // the n-th rising edge, which is where inputs change and outputs are read.
  task automatic edges(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] ph, input logic crst,
                            input logic [LW-1:0] loss);
    check({tag, ".Phase"}, 32'(Phase), 32'(ph));
    check({tag, ".CpuReset"}, 32'(CpuReset), 32'(crst));
    check({tag, ".Running"}, 32'(Running), 32'(!crst));
    check({tag, ".LockLossCount"}, 32'(LockLossCount), 32'(loss));
  endtask

  // From WAIT_LOCK with the synchroniser cleared: raise lock, reach RUN at edge L+H+2.
  task automatic bring_up(input string tag, input logic [LW-1:0] loss);
    PllLocked = 1'b1;
    edges(2 + L + H);
    check_outs({tag, ".pre_run"}, 2'd2, 1'b1, loss);
    edges(1);
    check_outs({tag, ".run"}, 2'd3, 1'b0, loss);
  endtask

  // Drop lock in RUN; reset reasserts two edges after the drop is sampled.
  task automatic lose_lock(input string tag, input logic [LW-1:0] loss_before,
                           input logic [LW-1:0] loss_after);
    PllLocked = 1'b0;
    edges(2);
    check_outs({tag, ".k1"}, 2'd3, 1'b0, loss_before);
    edges(1);
    check_outs({tag, ".k2"}, 2'd0, 1'b1, loss_after);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    Reset     = 1'b0;
    PllLocked = 1'b0;
    SoftReset = 1'b0;

    // Reset held low for three cycles.
    edges(3);
    check_outs("reset", 2'd0, 1'b1, 2'd0);

    // Power-up: lock high from edge 0.
    Reset     = 1'b1;
    PllLocked = 1'b1;
    edges(2);
    check_outs("pwr.e1", 2'd0, 1'b1, 2'd0);
    edges(1);
    check_outs("pwr.e2", 2'd1, 1'b1, 2'd0);
    edges(3);
    check_outs("pwr.e5", 2'd1, 1'b1, 2'd0);
    edges(1);
    check_outs("pwr.e6", 2'd2, 1'b1, 2'd0);
    edges(7);
    check_outs("pwr.e13", 2'd2, 1'b1, 2'd0);
    edges(1);
    check_outs("pwr.e14", 2'd3, 1'b0, 2'd0);
    edges(3);
    check_outs("pwr.hold_run", 2'd3, 1'b0, 2'd0);

    // SoftReset pulse in RUN, then a second pulse at HOLD counter 5.
    SoftReset = 1'b1;
    edges(1);
    check_outs("soft1.k", 2'd2, 1'b1, 2'd0);
    SoftReset = 1'b0;
    edges(5);
    check_outs("soft1.k5", 2'd2, 1'b1, 2'd0);
    SoftReset = 1'b1;
    edges(1);
    check_outs("soft2.k6", 2'd2, 1'b1, 2'd0);
    SoftReset = 1'b0;
    edges(2);
    check_outs("soft2.k8", 2'd2, 1'b1, 2'd0);
    edges(5);
    check_outs("soft2.k13", 2'd2, 1'b1, 2'd0);
    edges(1);
    check_outs("soft2.k14", 2'd3, 1'b0, 2'd0);

    // Simultaneous lock drop and SoftReset as seen by the FSM.
    PllLocked = 1'b0;
    edges(2);
    check_outs("simul.k1", 2'd3, 1'b0, 2'd0);
    SoftReset = 1'b1;
    edges(1);
    check_outs("simul.k2", 2'd0, 1'b1, 2'd1);
    SoftReset = 1'b0;
    edges(1);
    check_outs("simul.k3", 2'd0, 1'b1, 2'd1);

    // Back to RUN, then a second counted loss.
    bring_up("up2", 2'd1);
    lose_lock("loss2", 2'd1, 2'd2);
    bring_up("up3", 2'd2);

    // Reset in RUN with two losses recorded clears everything.
    Reset     = 1'b0;
    PllLocked = 1'b0;
    edges(1);
    check_outs("rst_run", 2'd0, 1'b1, 2'd0);
    Reset = 1'b1;

    // Unstable lock: one-cycle drop hits STABLE at counter 2.
    PllLocked = 1'b1;
    edges(3);
    check_outs("unst.e2", 2'd1, 1'b1, 2'd0);
    PllLocked = 1'b0;
    edges(1);
    PllLocked = 1'b1;
    edges(1);
    check_outs("unst.e4", 2'd1, 1'b1, 2'd0);
    edges(1);
    check_outs("unst.e5", 2'd0, 1'b1, 2'd0);
    edges(1);
    check_outs("unst.e6", 2'd1, 1'b1, 2'd0);
    edges(3);
    check_outs("unst.e9", 2'd1, 1'b1, 2'd0);
    edges(1);
    check_outs("unst.e10", 2'd2, 1'b1, 2'd0);
    edges(7);
    check_outs("unst.e17", 2'd2, 1'b1, 2'd0);
    edges(1);
    check_outs("unst.e18", 2'd3, 1'b0, 2'd0);

    // Five lock losses in RUN; counter saturates at 3.
    lose_lock("sat1", 2'd0, 2'd1);
    bring_up("sat1", 2'd1);
    lose_lock("sat2", 2'd1, 2'd2);
    bring_up("sat2", 2'd2);
    lose_lock("sat3", 2'd2, 2'd3);
    bring_up("sat3", 2'd3);
    lose_lock("sat4", 2'd3, 2'd3);
    bring_up("sat4", 2'd3);
    lose_lock("sat5", 2'd3, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
